// File: rtl/fb_pixel_reader_if.sv
// Frame-buffer pixel reader bus: BRAM read port plus pixel valid/request handshake.
// master = reader engine, slave = BRAM/VGA side.
interface fb_pixel_reader_if #(
   parameter int unsigned AW          = 16,
   parameter int unsigned RAM_WIDTH   = 18,
   parameter int unsigned PIXEL_WIDTH = 3
);
   logic                   frame_start_i;
   logic                   pix_req_i;
   logic [AW-1:0]          addra_o;
   logic                   ena_o;
   logic [RAM_WIDTH-1:0]   douta_i;
   logic [PIXEL_WIDTH-1:0] pix_o;
   logic                   pix_valid_o;
   logic                   underrun_o;

   modport master (
      input  frame_start_i, pix_req_i, douta_i,
      output addra_o, ena_o, pix_o, pix_valid_o, underrun_o
   );

   modport slave (
      output frame_start_i, pix_req_i, douta_i,
      input  addra_o, ena_o, pix_o, pix_valid_o, underrun_o
   );
endinterface

// File: rtl/fb_pixel_reader.sv
// Linear frame-buffer read engine with a 2-word prefetch buffer and pixel unpacker.
// Define FB_READER_MSB_FIRST_EN to place pixel 0 in the MSBs of each word.
module fb_pixel_reader #(
   parameter int unsigned RAM_WIDTH    = 18,
   parameter int unsigned RAM_DEPTH    = 51200,
   parameter int unsigned PIXEL_WIDTH  = 3,
   parameter int unsigned FRAME_PIXELS = 307200
) (
   input logic               clka,
   input logic               rsta,
   fb_pixel_reader_if.master bus
);

   localparam int unsigned AW          = $clog2(RAM_DEPTH - 1);
   localparam int unsigned PPW         = RAM_WIDTH / PIXEL_WIDTH;
   localparam int unsigned FRAME_WORDS = FRAME_PIXELS / PPW;
   localparam int unsigned IW          = (PPW > 1) ? $clog2(PPW) : 1;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic                   inflight_q, inflight_d;
   logic [RAM_WIDTH-1:0]   mem_q [2];
   logic [RAM_WIDTH-1:0]   mem_d [2];
   logic                   rd_ptr_q, rd_ptr_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic [1:0]             count_q, count_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
   logic                   underrun_q, underrun_d;

   logic pix_valid, adv, pop, capture, ena, last_issue;

   function automatic logic [PIXEL_WIDTH-1:0] unpack(input logic [RAM_WIDTH-1:0] w,
                                                     input logic [IW-1:0] k);
      logic [RAM_WIDTH-1:0] s;
`ifdef FB_READER_MSB_FIRST_EN
      s = w >> (RAM_WIDTH - (int'(k) + 1) * PIXEL_WIDTH);
`else
      s = w >> (int'(k) * PIXEL_WIDTH);
`endif
      return s[PIXEL_WIDTH-1:0];
   endfunction

   always_comb begin
      pix_valid  = (count_q != 2'd0);
      adv        = bus.pix_req_i && pix_valid && !bus.frame_start_i;
      pop        = adv && (idx_q == IW'(PPW - 1));
      capture    = inflight_q && !bus.frame_start_i;
      // Occupancy counts in-flight reads so the buffer can never overflow.
      ena        = (state_q == StFetch) && !bus.frame_start_i &&
                   ((int'(count_q) + int'(inflight_q) - int'(pop)) < 2);
      last_issue = ena && (addr_q == AW'(FRAME_WORDS - 1));

      state_d    = state_q;
      addr_d     = addr_q;
      inflight_d = inflight_q;
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      idx_d      = idx_q;
      underrun_d = underrun_q;

      if (bus.frame_start_i) begin
         // Dropping inflight discards the stale read still returning from the BRAM.
         state_d    = StFetch;
         addr_d     = '0;
         inflight_d = 1'b0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         count_d    = 2'd0;
         idx_d      = '0;
         underrun_d = 1'b0;
      end else begin
         inflight_d = ena;
         if (ena && !last_issue) addr_d = addr_q + 1'b1;
         if (last_issue) state_d = StDrain;
         if (capture) begin
            mem_d[wr_ptr_q] = bus.douta_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (adv) idx_d = pop ? '0 : idx_q + 1'b1;
         if (pop) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, capture} - {1'b0, pop};
         if (bus.pix_req_i && !pix_valid) underrun_d = 1'b1;
         if (state_q == StDrain && count_d == 2'd0) state_d = StIdle;
      end

      pix_d = (count_d != 2'd0) ? unpack(mem_d[rd_ptr_d], idx_d) : '0;
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         idx_q      <= '0;
         pix_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         pix_q      <= pix_d;
         underrun_q <= underrun_d;
      end
   end

   assign bus.addra_o     = addr_q;
   assign bus.ena_o       = ena;
   assign bus.pix_o       = pix_q;
   assign bus.pix_valid_o = pix_valid;
   assign bus.underrun_o  = underrun_q;

endmodule

// File: doc/fb_pixel_reader.md
# fb_pixel_reader

Read-side engine for the single-port frame-buffer BRAM in the VGA controller. It walks the BRAM linearly from word 0 after each frame-start pulse and absorbs the 1-cycle BRAM read latency in a 2-word prefetch buffer. It unpacks each word into pixels and presents them to the VGA output stage on a valid/request handshake. Writes never originate here: the block drives `ena`/`addra` only; the BRAM write enable is owned by the writer side.

## Interface
- `RAM_WIDTH`, 18, BRAM word width in bits.
- `RAM_DEPTH`, 51200, BRAM depth in words; address width is `$clog2(RAM_DEPTH-1)`.
- `PIXEL_WIDTH`, 3, bits per pixel; `RAM_WIDTH % PIXEL_WIDTH == 0`; `PPW = RAM_WIDTH/PIXEL_WIDTH` pixels per word.
- `FRAME_PIXELS`, 307200, pixels per frame; `FRAME_PIXELS % PPW == 0`; `FRAME_WORDS = FRAME_PIXELS/PPW <= RAM_DEPTH`.

Ports:
- `clka`  in  1  the single clock; all logic on its rising edge.
- `rsta`  in  1  reset, asynchronous, active-high.
- `frame_start_i`  in  1  one-cycle pulse; aborts any frame and restarts at word 0.
- `pix_req_i`  in  1  consumer takes `pix_o` this cycle.
- `addra_o`  out  AW  BRAM read address.
- `ena_o`  out  1  BRAM enable (read strobe).
- `douta_i`  in  RAM_WIDTH  BRAM read data, valid the cycle after `ena_o` is sampled.
- `pix_o`  out  PIXEL_WIDTH  current pixel.
- `pix_valid_o`  out  1  `pix_o` holds a valid pixel.
- `underrun_o`  out  1  sticky: request made while `pix_valid_o` was low.

## Operation
- Reset values: `addra_o`=0, `ena_o`=0, `pix_o`=0, `pix_valid_o`=0, `underrun_o`=0; buffer empty; state IDLE.
- States:
  - IDLE: no fetches. `frame_start_i` -> FETCH.
  - FETCH: issues reads until `FRAME_WORDS` have been issued -> DRAIN.
  - DRAIN: no new reads. Last pixel consumed -> IDLE.
- Fetch rule: `ena_o`=1 in a cycle iff state is FETCH, `frame_start_i` is low, and (buffered words + in-flight reads − words popped this cycle) < 2. `addra_o` increments after each issued read and runs 0 .. `FRAME_WORDS-1`; it never wraps within a frame.
- Capture: a read issued in cycle N is written into the buffer at the end of cycle N+1 from `douta_i`, unless it has been flushed.
- Unpack: pixel k of a word is bits `[k*PIXEL_WIDTH +: PIXEL_WIDTH]`, LSB-first. A pixel index 0..PPW-1 selects the pixel of the head word.
- `pix_valid_o`=1 iff the buffer is non-empty. `pix_o` is registered, and is 0 whenever `pix_valid_o` is 0.
- Pop and advance: `pix_req_i` with `pix_valid_o` high advances the pixel index. At index PPW-1 the index returns to 0 and the head word is popped.
- Underrun: `pix_req_i` with `pix_valid_o` low sets `underrun_o` and is otherwise ignored. The flag is cleared only by `frame_start_i` or `rsta`.
- `frame_start_i` in any state, including mid-frame: flush the buffer, reset the pixel index and `addra_o` to 0, clear `underrun_o`, and mark the in-flight read (if any) for discard. `ena_o`=0 that cycle. State -> FETCH.
- `frame_start_i` and `pix_req_i` in the same cycle: the flush wins and the request is dropped without setting underrun.
- `rsta` asserted mid-frame: all state returns to reset values immediately.

## Timing
- `frame_start_i` high in cycle 0 -> `ena_o`=1 with `addra_o`=0 in cycle 1 -> data captured at the end of cycle 2 -> `pix_valid_o`=1 in cycle 3.
- Second read (`addra_o`=1) is issued in cycle 2.
- Sustained throughput is one pixel per cycle for any PPW ≥ 1 once primed.
- Each pixel is consumed on the cycle `pix_req_i` is high. The next pixel appears on `pix_o` the following cycle.

## Configuration
- `FB_READER_MSB_FIRST_EN`:
  - Defined: pixel k of a word is bits `[RAM_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH]`, so pixel 0 is in the MSBs.
  - Undefined: LSB-first packing as described in Operation.
- All other behaviour is identical with and without the macro.

## Test plan
All scenarios use `RAM_WIDTH`=6, `PIXEL_WIDTH`=3, `FRAME_PIXELS`=8, `RAM_DEPTH`=4.
- Prime latency: BRAM words {6'o21, 6'o43, 6'o65, 6'o07}, pulse `frame_start_i` at cycle 0 -> `ena_o`/`addra_o`=0 in cycle 1, `addra_o`=1 in cycle 2, `pix_valid_o`=1 with `pix_o`=1 in cycle 3.
- Full frame: hold `pix_req_i`=1 from cycle 3 -> `pix_o` sequence 1,2,3,4,5,6,7,0 on consecutive cycles -> `pix_valid_o`=0 afterwards, state IDLE, `underrun_o`=0, exactly 4 reads issued.
- Back-pressure: hold `pix_req_i`=0 for 20 cycles after priming -> exactly 2 reads issued, `pix_o` stays 1, no further `ena_o`.
- Underrun: pulse `pix_req_i` in cycle 1 -> `underrun_o`=1 and stays 1 through the frame. Next `frame_start_i` -> 0.
- Mid-frame restart: after 3 pixels consumed, pulse `frame_start_i` while a read is in flight -> stale data discarded, `pix_o`=1 three cycles later.
- Macro defined: same memory -> `pix_o` sequence 2,1,4,3,6,5,0,7.
